// File: rtl/sga_frame_tx_if.sv
// Game-state snapshot and serial status bundle for sga_frame_tx.
// The master side supplies the game state and the send request; the slave
// side (the transmitter) returns the serial line and frame status.
interface sga_frame_tx_if;

   // Frame request and game-state fields
   logic       send;
   logic [5:0] head;
   logic [5:0] apple;
   logic [4:0] state;
   logic [1:0] direction;
   logic [5:0] size;
   logic       won;
   logic       lost;
   logic       comeu_maca;

   // Serial line and frame status
   logic       tx;
   logic       busy;
   logic       done;

   modport master (
      output send,
      output head,
      output apple,
      output state,
      output direction,
      output size,
      output won,
      output lost,
      output comeu_maca,
      input  tx,
      input  busy,
      input  done
   );

   modport slave (
      input  send,
      input  head,
      input  apple,
      input  state,
      input  direction,
      input  size,
      input  won,
      input  lost,
      input  comeu_maca,
      output tx,
      output busy,
      output done
   );

endinterface

// File: rtl/sga_frame_tx.sv
// Snake Game Arcade state-frame UART transmitter (8N1, LSB first).
// Streams SYNC_BYTE, head, apple, flags/state and direction/size bytes.
// Optional: define SGA_FRAME_CHECKSUM_EN to append an XOR checksum byte
// (B1^B2^B3^B4) after B4, giving a six-byte frame instead of five.
module sga_frame_tx #(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
   input logic           clock,
   input logic           restart_n,
   sga_frame_tx_if.slave bus
);

`ifdef SGA_FRAME_CHECKSUM_EN
   localparam int unsigned NBYTES = 6;
`else
   localparam int unsigned NBYTES = 5;
`endif

   localparam logic [15:0] BaudMax  = 16'(CLKS_PER_BIT - 1);
   localparam logic [2:0]  LastByte = 3'(NBYTES - 1);
   localparam logic [2:0]  LastBit  = 3'd7;

   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StData,
      StStop
   } fsm_e;

   // State registers
   fsm_e        fsm_q, fsm_d;
   logic [15:0] baud_q, baud_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic [2:0]  byte_idx_q, byte_idx_d;
   logic        tx_q, tx_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   // Snapshot of the game state taken on the accepting edge
   logic [5:0]  snap_head_q, snap_head_d;
   logic [5:0]  snap_apple_q, snap_apple_d;
   logic [4:0]  snap_state_q, snap_state_d;
   logic [1:0]  snap_dir_q, snap_dir_d;
   logic [5:0]  snap_size_q, snap_size_d;
   logic        snap_won_q, snap_won_d;
   logic        snap_lost_q, snap_lost_d;
   logic        snap_eat_q, snap_eat_d;

   // Frame bytes derived from the snapshot
   logic [7:0]  byte_head;
   logic [7:0]  byte_apple;
   logic [7:0]  byte_flags;
   logic [7:0]  byte_motion;
   logic [7:0]  cur_byte;
   logic [2:0]  next_bit;
   logic        bit_end;

   assign byte_head   = {2'b00, snap_head_q};
   assign byte_apple  = {2'b00, snap_apple_q};
   assign byte_flags  = {snap_won_q, snap_lost_q, snap_eat_q, snap_state_q};
   assign byte_motion = {snap_dir_q, snap_size_q};

   assign bit_end  = (baud_q == BaudMax);
   assign next_bit = bit_idx_q + 3'd1;

   // Select the byte currently being shifted out
   always_comb begin
      cur_byte = 8'h00;
      case (byte_idx_q)
         3'd0:    cur_byte = SYNC_BYTE;
         3'd1:    cur_byte = byte_head;
         3'd2:    cur_byte = byte_apple;
         3'd3:    cur_byte = byte_flags;
         3'd4:    cur_byte = byte_motion;
`ifdef SGA_FRAME_CHECKSUM_EN
         3'd5:    cur_byte = byte_head ^ byte_apple ^ byte_flags ^ byte_motion;
`endif
         default: cur_byte = 8'h00;
      endcase
   end

   // Next-state logic: bit timing, byte sequencing and registered tx level
   always_comb begin
      fsm_d        = fsm_q;
      baud_d       = baud_q;
      bit_idx_d    = bit_idx_q;
      byte_idx_d   = byte_idx_q;
      tx_d         = tx_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      snap_head_d  = snap_head_q;
      snap_apple_d = snap_apple_q;
      snap_state_d = snap_state_q;
      snap_dir_d   = snap_dir_q;
      snap_size_d  = snap_size_q;
      snap_won_d   = snap_won_q;
      snap_lost_d  = snap_lost_q;
      snap_eat_d   = snap_eat_q;

      unique case (fsm_q)
         StIdle: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
            if (bus.send) begin
               snap_head_d  = bus.head;
               snap_apple_d = bus.apple;
               snap_state_d = bus.state;
               snap_dir_d   = bus.direction;
               snap_size_d  = bus.size;
               snap_won_d   = bus.won;
               snap_lost_d  = bus.lost;
               snap_eat_d   = bus.comeu_maca;
               byte_idx_d   = 3'd0;
               bit_idx_d    = 3'd0;
               baud_d       = 16'd0;
               busy_d       = 1'b1;
               // Start bit appears on the very next cycle
               tx_d         = 1'b0;
               fsm_d        = StStart;
            end
         end

         StStart: begin
            if (bit_end) begin
               baud_d    = 16'd0;
               bit_idx_d = 3'd0;
               tx_d      = cur_byte[0];
               fsm_d     = StData;
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end

         StData: begin
            if (bit_end) begin
               baud_d = 16'd0;
               if (bit_idx_q == LastBit) begin
                  tx_d  = 1'b1;
                  fsm_d = StStop;
               end else begin
                  bit_idx_d = next_bit;
                  tx_d      = cur_byte[next_bit];
               end
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end

         StStop: begin
            if (bit_end) begin
               baud_d = 16'd0;
               if (byte_idx_q != LastByte) begin
                  // Next byte starts immediately, no idle gap inside a frame
                  byte_idx_d = byte_idx_q + 3'd1;
                  tx_d       = 1'b0;
                  fsm_d      = StStart;
               end else begin
                  byte_idx_d = 3'd0;
                  tx_d       = 1'b1;
                  busy_d     = 1'b0;
                  done_d     = 1'b1;
                  fsm_d      = StIdle;
               end
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end

         default: begin
            fsm_d  = StIdle;
            tx_d   = 1'b1;
            busy_d = 1'b0;
         end
      endcase
   end

   // State register; reset abandons any frame in flight
   always_ff @(posedge clock or negedge restart_n) begin
      if (!restart_n) begin
         fsm_q        <= StIdle;
         baud_q       <= 16'd0;
         bit_idx_q    <= 3'd0;
         byte_idx_q   <= 3'd0;
         tx_q         <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         snap_head_q  <= 6'd0;
         snap_apple_q <= 6'd0;
         snap_state_q <= 5'd0;
         snap_dir_q   <= 2'd0;
         snap_size_q  <= 6'd0;
         snap_won_q   <= 1'b0;
         snap_lost_q  <= 1'b0;
         snap_eat_q   <= 1'b0;
      end else begin
         fsm_q        <= fsm_d;
         baud_q       <= baud_d;
         bit_idx_q    <= bit_idx_d;
         byte_idx_q   <= byte_idx_d;
         tx_q         <= tx_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         snap_head_q  <= snap_head_d;
         snap_apple_q <= snap_apple_d;
         snap_state_q <= snap_state_d;
         snap_dir_q   <= snap_dir_d;
         snap_size_q  <= snap_size_d;
         snap_won_q   <= snap_won_d;
         snap_lost_q  <= snap_lost_d;
         snap_eat_q   <= snap_eat_d;
      end
   end

   // Outputs come straight from registers so tx never glitches
   assign bus.tx   = tx_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;

endmodule

// File: doc/sga_frame_tx.md
Name: sga_frame_tx

Overview:
- UART transmitter that streams a snapshot of Snake Game Arcade state to an external host/display over one serial line.
- Sits beside the game top level; consumes head, apple, state, direction, size and win/loss/apple-eaten flags.
- Serializes them into a fixed byte frame, 8N1, LSB first.
- A host-side receiver decodes the frame, so the block is the output end of the game-state interface.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200 baud); legal range 2..65535.
- SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
- clock  input  1  system clock, rising edge.
- restart_n  input  1  asynchronous active-low reset.
- send  input  1  request a frame; sampled only in IDLE.
- head  input  6  snake head position {Y[2:0], X[2:0]}.
- apple  input  6  apple position {Y[2:0], X[2:0]}.
- state  input  5  controller state code.
- direction  input  2  current movement direction.
- size  input  6  snake length.
- won  input  1  game won flag.
- lost  input  1  game lost flag.
- comeu_maca  input  1  apple-eaten flag.
- tx  output  1  serial line, idle high.
- busy  output  1  high from frame acceptance until the last stop bit ends.
- done  output  1  one-cycle pulse at frame completion.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (restart_n=0, asynchronous): tx=1, busy=0, done=0, FSM=IDLE, all counters=0, snapshot registers=0. Applies at any point, including mid-bit or mid-frame. The frame is abandoned; no resume after release.
- Frame bytes, in order:
  - B0 = SYNC_BYTE
  - B1 = {2'b00, head}
  - B2 = {2'b00, apple}
  - B3 = {won, lost, comeu_maca, state}
  - B4 = {direction, size}
- Snapshot: all data inputs are registered on the accepting edge. Input changes during transmission do not affect the frame in flight.
- Byte format: start bit 0, data bits D0..D7 (LSB first), stop bit 1. Every bit is exactly CLKS_PER_BIT cycles.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. When send=1 on a clock edge: capture snapshot, byte_idx=0, bit counter=0, busy=1, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: tx=current_byte[bit_idx], held CLKS_PER_BIT cycles per bit. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then, if byte_idx < NBYTES-1: byte_idx++ and go to START (no idle gap between bytes). Otherwise go to IDLE, busy=0, done=1 for one cycle.
- Latency: tx falls on the first cycle after the accepting edge.
- Frame length: NBYTES*10*CLKS_PER_BIT cycles from tx falling to busy falling.
- Frame ordering: done and busy falling occur on the same edge. The earliest next accept is the following edge, if send=1.
- send while busy: ignored, not queued.
- send held high continuously: back-to-back frames, one idle cycle (tx=1) between frames.
- Counters:
  - Baud counter is 16-bit, compares against CLKS_PER_BIT-1, clears on each bit boundary.
  - bit_idx is 3-bit; byte_idx is 3-bit.
- tx is driven from a register; no combinational glitches.

Optional Feature:
- Macro: SGA_FRAME_CHECKSUM_EN.
- Defined: NBYTES=6. B5 = B1^B2^B3^B4, computed from the snapshot and sent after B4.
- Undefined: NBYTES=5, no checksum byte. All other timing rules are unchanged.

Test Plan:
- Reset idle: restart_n=0 then 1, no send, CLKS_PER_BIT=4 -> tx=1, busy=0, done=0 for 100 cycles.
- Single frame: CLKS_PER_BIT=4, head=6'h2B, apple=6'h05, state=5'h0C, direction=2, size=3, won=0, lost=0, comeu_maca=1, pulse send -> decoded bytes A5 2B 05 2C 83. busy high 200 cycles; one done pulse.
- Checksum build (SGA_FRAME_CHECKSUM_EN): same inputs -> sixth byte 2B^05^2C^83 = 0x81; busy high 240 cycles.
- Snapshot/ignore: change head to 6'h3F and pulse send during byte B2 -> frame still carries 2B; no second frame starts after done.
- Reset mid-frame: assert restart_n=0 during DATA of B3 -> tx=1 and busy=0 immediately (asynchronous). No done pulse; the next send produces a full clean frame starting with A5.
- Continuous send: send held 1 for two frames -> exactly one idle cycle with tx=1 between the B4 stop bit and the next start bit; two done pulses.
